// File: rtl/dmem_responder.sv
// dmem_responder: data-memory port for the EX/MEM stage.
// Stores are posted into a small write buffer that drains into a single-port word RAM.
// Loads return combinationally, forwarding from the newest matching buffer entry.
// Optional feature macro: DMEM_MISALIGN_EN builds the sticky misalignment flag on mem_err;
// without it mem_err is tied low.
//
// Drain FSM states:
//   state     | meaning
//   ST_IDLE   | buffer empty or waiting one cycle for a fresh entry
//   ST_LOAD   | latch head entry {index, data} for the RAM write
//   ST_COMMIT | write RAM and pop head; yields the port to any read this cycle
module dmem_responder #(
    parameter int ADDR_W     = 10,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          memRead,
    input  logic                          memWrite,
    input  logic [31:0]                   adr_Mem,
    input  logic [31:0]                   writeData_Mem,
    output logic [31:0]                   readData_Mem,
    output logic                          mem_stall,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
    output logic                          mem_err
);

    localparam int PTR_W     = $clog2(WBUF_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int RAM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT
    } drain_state_t;

    drain_state_t        state, state_next;
    logic [PTR_W-1:0]    head_ptr, tail_ptr;
    logic [CNT_W-1:0]    count, count_next;
    logic [ADDR_W-1:0]   buf_idx  [WBUF_DEPTH];
    logic [31:0]         buf_data [WBUF_DEPTH];
    logic [ADDR_W-1:0]   commit_idx;
    logic [31:0]         commit_data;
    logic [31:0]         ram [RAM_DEPTH];

    logic [ADDR_W-1:0]   acc_idx;
    logic                full;
    logic                push;
    logic                pop;
    logic                fwd_hit;
    logic [31:0]         fwd_data;
    logic [PTR_W-1:0]    slot;

    // Byte offset and high address bits do not select data; addresses alias.
    logic unused_adr;
    assign unused_adr = ^{adr_Mem[31:ADDR_W+2], adr_Mem[1:0]};

    assign acc_idx    = adr_Mem[ADDR_W+1:2];
    assign full       = (count == CNT_W'(WBUF_DEPTH));
    // A read owns the single RAM port, so the commit waits while memRead is high.
    assign pop        = (state == ST_COMMIT) && !memRead;
    // A pop in the same cycle frees a slot, so a full buffer still accepts the push.
    assign push       = memWrite && (!full || pop);
    assign mem_stall  = memWrite && full && !pop;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign wbuf_count = count;

    // Pointer, occupancy and drain-state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
        end
    end

    // Buffer storage; occupancy alone defines which slots are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_idx[tail_ptr]  <= acc_idx;
            buf_data[tail_ptr] <= writeData_Mem;
        end
    end

    // Capture the head entry while in LOAD for the following commit.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            commit_idx  <= buf_idx[head_ptr];
            commit_data <= buf_data[head_ptr];
        end
    end

    // RAM write port; gated by the FSM state, so reset mid-drain leaves RAM untouched.
    always_ff @(posedge clk) begin
        if (pop) ram[commit_idx] <= commit_data;
    end

    // Drain next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (count != '0) state_next = ST_LOAD;
            ST_LOAD:   state_next = ST_COMMIT;
            ST_COMMIT: if (pop) state_next = (count_next != '0) ? ST_LOAD : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Forwarding search, oldest to newest so the newest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            slot = head_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (buf_idx[slot] == acc_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[slot];
            end
        end
    end

    // Load data mux: buffer first, then RAM; zero when no read.
    always_comb begin
        readData_Mem = '0;
        if (memRead) readData_Mem = fwd_hit ? fwd_data : ram[acc_idx];
    end

`ifdef DMEM_MISALIGN_EN
    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_err <= 1'b0;
        else if ((memRead || memWrite) && (adr_Mem[1:0] != 2'b00))
            mem_err <= 1'b1;
    end
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table covering forwarding, buffer
// fill/stall and commit hold-off, then hand sequences for misalignment and reset mid-drain.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        memRead;
    logic        memWrite;
    logic [31:0] adr_Mem;
    logic [31:0] writeData_Mem;
    logic [31:0] readData_Mem;
    logic        mem_stall;
    logic [2:0]  wbuf_count;
    logic        mem_err;

    int tests = 0;
    int fails = 0;

`ifdef DMEM_MISALIGN_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    dmem_responder #(.ADDR_W(10), .WBUF_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .adr_Mem       (adr_Mem),
        .writeData_Mem (writeData_Mem),
        .readData_Mem  (readData_Mem),
        .mem_stall     (mem_stall),
        .wbuf_count    (wbuf_count),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        est;
        int          ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string n, input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] erd, input logic est, input int ecnt);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.adr = a; v.wd = wd;
        v.erd = erd; v.est = est; v.ecnt = ecnt;
        tbl.push_back(v);
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs at the falling edge, then pass the rising edge.
    task automatic apply(input string nm, input logic rd, input logic wr,
                         input logic [31:0] adr, input logic [31:0] wd,
                         input logic [31:0] erd, input logic est, input int ecnt,
                         input logic eerr);
        memRead       = rd;
        memWrite      = wr;
        adr_Mem       = adr;
        writeData_Mem = wd;
        @(negedge clk);
        check32({nm, ":rdata"}, readData_Mem, erd);
        check32({nm, ":stall"}, 32'(mem_stall), 32'(est));
        check32({nm, ":count"}, 32'(wbuf_count), 32'(ecnt));
        check32({nm, ":err"},   32'(mem_err), 32'(eerr));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; adr_Mem = '0; writeData_Mem = '0;

        // Forward then drain of a single store.
        add("t2_wr",   0, 1, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0);
        add("t2_fwd",  1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1);
        add("t2_load", 0, 0, 32'h0,  32'h0,        32'h0,        0, 1);
        add("t2_cmt",  0, 0, 32'h0,  32'h0,        32'h0,        0, 1);
        add("t2_ram",  1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0);
        // Back-to-back stores; drain overlaps so the first stall is on the 7th attempt.
        add("t3_w0",   0, 1, 32'h00, 32'h100, 32'h0, 0, 0);
        add("t3_w1",   0, 1, 32'h04, 32'h101, 32'h0, 0, 1);
        add("t3_w2",   0, 1, 32'h08, 32'h102, 32'h0, 0, 2);
        add("t3_w3",   0, 1, 32'h0C, 32'h103, 32'h0, 0, 3);
        add("t3_w4",   0, 1, 32'h10, 32'h104, 32'h0, 0, 3);
        add("t3_w5",   0, 1, 32'h14, 32'h105, 32'h0, 0, 4);
        add("t3_w6s",  0, 1, 32'h18, 32'h106, 32'h0, 1, 4);
        add("t3_w6",   0, 1, 32'h18, 32'h106, 32'h0, 0, 4);
        add("t3_w7s",  0, 1, 32'h1C, 32'h107, 32'h0, 1, 4);
        add("t3_w7",   0, 1, 32'h1C, 32'h107, 32'h0, 0, 4);
        add("t3_d0",   0, 0, 32'h0,  32'h0,   32'h0, 0, 4);
        add("t3_d1",   0, 0, 32'h0,  32'h0,   32'h0, 0, 4);
        add("t3_d2",   0, 0, 32'h0,  32'h0,   32'h0, 0, 3);
        add("t3_d3",   0, 0, 32'h0,  32'h0,   32'h0, 0, 3);
        add("t3_d4",   0, 0, 32'h0,  32'h0,   32'h0, 0, 2);
        add("t3_d5",   0, 0, 32'h0,  32'h0,   32'h0, 0, 2);
        add("t3_d6",   0, 0, 32'h0,  32'h0,   32'h0, 0, 1);
        add("t3_d7",   0, 0, 32'h0,  32'h0,   32'h0, 0, 1);
        add("t3_r0",   1, 0, 32'h00, 32'h0, 32'h100, 0, 0);
        add("t3_r1",   1, 0, 32'h04, 32'h0, 32'h101, 0, 0);
        add("t3_r2",   1, 0, 32'h08, 32'h0, 32'h102, 0, 0);
        add("t3_r3",   1, 0, 32'h0C, 32'h0, 32'h103, 0, 0);
        add("t3_r4",   1, 0, 32'h10, 32'h0, 32'h104, 0, 0);
        add("t3_r5",   1, 0, 32'h14, 32'h0, 32'h105, 0, 0);
        add("t3_r6",   1, 0, 32'h18, 32'h0, 32'h106, 0, 0);
        add("t3_r7",   1, 0, 32'h1C, 32'h0, 32'h107, 0, 0);
        // Newest entry wins; reads in COMMIT hold off the pop.
        add("t4_w1",   0, 1, 32'h20, 32'h1, 32'h0, 0, 0);
        add("t4_w2",   0, 1, 32'h20, 32'h2, 32'h0, 0, 1);
        add("t4_rl",   1, 0, 32'h20, 32'h0, 32'h2, 0, 2);
        add("t5_h0",   1, 0, 32'h20, 32'h0, 32'h2, 0, 2);
        add("t5_h1",   1, 0, 32'h20, 32'h0, 32'h2, 0, 2);
        add("t5_h2",   1, 0, 32'h20, 32'h0, 32'h2, 0, 2);
        add("t5_pop",  0, 0, 32'h0,  32'h0, 32'h0, 0, 2);
        add("t5_rl2",  1, 0, 32'h20, 32'h0, 32'h2, 0, 1);
        add("t5_h3",   1, 0, 32'h20, 32'h0, 32'h2, 0, 1);
        add("t5_pop2", 0, 0, 32'h0,  32'h0, 32'h0, 0, 1);
        add("t5_ram",  1, 0, 32'h20, 32'h0, 32'h2, 0, 0);

        // Reset state.
        repeat (2) @(negedge clk);
        check32("rst:count", 32'(wbuf_count), 32'h0);
        check32("rst:stall", 32'(mem_stall), 32'h0);
        check32("rst:err",   32'(mem_err), 32'h0);
        check32("rst:rdata", readData_Mem, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i])
            apply(tbl[i].name, tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].wd,
                  tbl[i].erd, tbl[i].est, tbl[i].ecnt, 1'b0);

        // Misaligned read still returns the word; high bits alias.
        apply("mis_rd",    1, 0, 32'h13,   32'h0, 32'h104, 0, 0, 1'b0);
        apply("mis_idle",  0, 0, 32'h0,    32'h0, 32'h0,   0, 0, ERR_EXP);
        apply("alias_rd",  1, 0, 32'h1010, 32'h0, 32'h104, 0, 0, ERR_EXP);
        apply("mis_stick", 0, 0, 32'h0,    32'h0, 32'h0,   0, 0, ERR_EXP);
        rst_n = 1'b0;
        @(negedge clk);
        check32("mis_rst:err", 32'(mem_err), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset while in COMMIT must drop the entry without writing RAM.
        apply("rd_w55",  0, 1, 32'h24, 32'h55, 32'h0,  0, 0, 1'b0);
        apply("rd_i0",   0, 0, 32'h0,  32'h0,  32'h0,  0, 1, 1'b0);
        apply("rd_i1",   0, 0, 32'h0,  32'h0,  32'h0,  0, 1, 1'b0);
        apply("rd_i2",   0, 0, 32'h0,  32'h0,  32'h0,  0, 1, 1'b0);
        apply("rd_chk",  1, 0, 32'h24, 32'h0,  32'h55, 0, 0, 1'b0);
        apply("rd_wAA",  0, 1, 32'h24, 32'hAA, 32'h0,  0, 0, 1'b0);
        apply("rd_fwd",  1, 0, 32'h24, 32'h0,  32'hAA, 0, 1, 1'b0);
        apply("rd_load", 0, 0, 32'h0,  32'h0,  32'h0,  0, 1, 1'b0);
        memRead = 1'b0; memWrite = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check32("mid_rst:count", 32'(wbuf_count), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply("mid_rst_ram", 1, 0, 32'h24, 32'h0, 32'h55, 0, 0, 1'b0);
        apply("mid_rst_idl", 0, 0, 32'h0,  32'h0, 32'h0,  0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
